// File: rtl/fm_pp_accum_if.sv
// Item stream bundle for the partial-product accumulate pipe:
// upstream offer/accept on the in_* side, reduced result on the out_* side.
interface fm_pp_accum_if #(
  parameter int W    = 22,
  parameter int ROWS = 8,
  parameter int EXW  = 8
);
  logic                in_valid;
  logic                in_ready;
  logic [EXW-1:0]      in_ex;
  logic                in_sign;
  logic [W-1:0]        in_sum;
  logic [ROWS*W-1:0]   in_pp;
  logic [W-1:0]        in_pp_next;

  logic                out_valid;
  logic                out_ready;
  logic [EXW-1:0]      out_ex;
  logic                out_sign;
  logic [W-1:0]        out_sum;
  logic [W-1:0]        out_pp_next;
  logic                out_ovf;

  modport master (
    output in_valid, in_ex, in_sign, in_sum, in_pp, in_pp_next, out_ready,
    input  in_ready, out_valid, out_ex, out_sign, out_sum, out_pp_next, out_ovf
  );

  modport slave (
    input  in_valid, in_ex, in_sign, in_sum, in_pp, in_pp_next, out_ready,
    output in_ready, out_valid, out_ex, out_sign, out_sum, out_pp_next, out_ovf
  );
endinterface

// File: rtl/fm_pp_accum_pipe.sv
// Partial-product accumulate pipe: stage k adds row k-1 into the running sum,
// one row per stage, with a single global stall enable and sticky carry-out flag.
module fm_pp_accum_pipe #(
  parameter int W    = 22,
  parameter int ROWS = 8,
  parameter int EXW  = 8
) (
  input  logic           CLK,
  input  logic           RESETn,
  input  logic           flush,
  fm_pp_accum_if.slave   bus
);

  logic ce;

  assign ce           = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = ce;

  for (genvar g = 0; g < ROWS; g++) begin : stg
    logic                  vld_in;
    logic                  ovf_in;
    logic                  sign_in;
    logic [W-1:0]          sum_in;
    logic [W-1:0]          ppn_in;
    logic [EXW-1:0]        ex_in;
    logic [(ROWS-g)*W-1:0] pp_in;

    logic [W-1:0]          add_s;
    logic                  add_c;

    logic                  vld_q;
    logic                  ovf_q;
    logic                  sign_q;
    logic [W-1:0]          sum_q;
    logic [W-1:0]          ppn_q;
    logic [EXW-1:0]        ex_q;

    if (g == 0) begin : head
      assign vld_in  = bus.in_valid;
      assign ovf_in  = 1'b0;
      assign sign_in = bus.in_sign;
      assign sum_in  = bus.in_sum;
      assign ppn_in  = bus.in_pp_next;
      assign ex_in   = bus.in_ex;
      assign pp_in   = bus.in_pp;
    end else begin : link
      assign vld_in  = stg[g-1].vld_q;
      assign ovf_in  = stg[g-1].ovf_q;
      assign sign_in = stg[g-1].sign_q;
      assign sum_in  = stg[g-1].sum_q;
      assign ppn_in  = stg[g-1].ppn_q;
      assign ex_in   = stg[g-1].ex_q;
      assign pp_in   = stg[g-1].dly.pp_q;
    end

    // Row 0 of the remaining rows is consumed here; carry only reaches the ovf flag.
    always_comb begin
      logic c;
      c     = 1'b0;
      add_s = '0;
      for (int i = 0; i < W; i++) begin
        add_s[i] = sum_in[i] ^ pp_in[i] ^ c;
        c        = (sum_in[i] & pp_in[i]) | (c & (sum_in[i] ^ pp_in[i]));
      end
      add_c = c;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
        vld_q  <= 1'b0;
        ovf_q  <= 1'b0;
        sign_q <= 1'b0;
        sum_q  <= '0;
        ppn_q  <= '0;
        ex_q   <= '0;
      end else if (flush) begin
        vld_q <= 1'b0;
        ovf_q <= 1'b0;
      end else if (ce) begin
        vld_q  <= vld_in;
        ovf_q  <= ovf_in | add_c;
        sign_q <= sign_in;
        sum_q  <= add_s;
        ppn_q  <= ppn_in;
        ex_q   <= ex_in;
      end
    end

    // Rows not yet consumed travel with the item; the last stage has none left.
    if (g < ROWS-1) begin : dly
      logic [(ROWS-1-g)*W-1:0] pp_q;

      always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn)
          pp_q <= '0;
        else if (ce)
          pp_q <= pp_in[(ROWS-g)*W-1:W];
      end
    end
  end

  assign bus.out_valid   = stg[ROWS-1].vld_q;
  assign bus.out_ovf     = stg[ROWS-1].ovf_q;
  assign bus.out_sign    = stg[ROWS-1].sign_q;
  assign bus.out_sum     = stg[ROWS-1].sum_q;
  assign bus.out_pp_next = stg[ROWS-1].ppn_q;
  assign bus.out_ex      = stg[ROWS-1].ex_q;

endmodule
